uart_fifo_io: RTL
=================

// Module: uart_fifo_io
// PURPOSE
//  Memory-mapped UART peripheral with parametrised TX/RX FIFOs, a runtime baud divisor,
//  sticky error flags and a level interrupt. It replaces the single-byte UART_IO, sits behind
//  the same tri-state IO_wrapper on the CPU data bus, and uses the same MemEn/MemWen strobes.
// PARAMETERS
//  CLK_DIV_RST  868  reset value of the DIVISOR reg (clk cycles per bit); 115200 baud @100MHz
//  TX_DEPTH     8    TX FIFO entries (power of 2, >=2)
//  RX_DEPTH     8    RX FIFO entries (power of 2, >=2)
// PORTS
//  clk       in   1   system clock, all logic on posedge
//  rst_n     in   1   asynchronous, active-low reset
//  addr      in   4   register word index
//  data_in   in   32  CPU write data
//  data_out  out  32  CPU read data, registered
//  MemEn     in   1   access strobe
//  MemWen    in   1   1=write, 0=read (qualified by MemEn)
//  tx        out  1   serial out, idle high
//  rx        in   1   serial in, asynchronous
//  busy      out  1   tx_busy | rx_busy
//  irq       out  1   level interrupt
// BEHAVIOUR
//  Reset: tx=1, data_out=0, busy=0, irq=0, FIFOs empty, CTRL=0, DIVISOR=CLK_DIV_RST, flags=0.
//   Reset asserted mid-frame aborts the frame immediately (tx=1 in the same cycle).
//  Regs: 0 CTRL [0]tx_en [1]rx_en [2]rx_ie [3]tx_ie [4]loopback, RW.
//   1 DATA: a write pushes data_in[7:0] to the TX FIFO; a read pops the RX FIFO ({24'b0,byte}).
//   2 STATUS, RO except W1C: [0]tx_full [1]tx_empty [2]rx_empty [3]rx_full [4]tx_busy
//   [5]rx_busy [6]rx_ovr* [7]frame_err* [8]tx_ovr* [9]parity_err*. *Sticky; write 1 to clear.
//   3 DIVISOR [15:0], RW. Values <4 are clamped to 4. Other addresses read 0; writes ignored.
//  Read latency: data_out is valid on the cycle after MemEn&~MemWen. The DATA read pops once
//   per strobe cycle. A pop while the FIFO is empty returns 0 and leaves no state change.
//  TX push when full: byte dropped, tx_ovr set. A simultaneous CPU push and serializer pop on
//   a full FIFO both succeed.
//  TX FSM: IDLE->START->DATA(8 bits, LSB first)->[PARITY]->STOP->IDLE. Each state lasts
//   DIVISOR cycles. It leaves IDLE when tx_en=1 and the FIFO is non-empty, popping at that edge.
//   DIVISOR is latched at START, so writes mid-frame apply to the next frame. Back-to-back
//   frames have no idle gap. Clearing tx_en mid-frame finishes the current frame, then stops.
//  RX: 2-FF synchronizer; rx_src = loopback ? tx : rx_sync.
//   FSM IDLE->START->DATA->[PARITY]->STOP->IDLE. It arms on a falling edge when rx_en=1.
//   The start bit is re-sampled at DIVISOR/2; if high, it is a false start and the FSM returns
//   to IDLE. Later samples come every DIVISOR cycles after the mid-start point.
//   Stop=0: frame_err set, byte discarded. RX FIFO full: rx_ovr set, new byte dropped.
//   A push and a CPU pop in the same cycle on a full FIFO both succeed.
//  irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty & ~tx_busy) | (rx_ie & (rx_ovr|frame_err|parity_err)).
//  Pointers are log2(DEPTH)+1 bits; full/empty are decided by MSB compare; the wrap is natural.
// CONFIGURATION
//  UART_PARITY_EN defined: CTRL[5] par_en, CTRL[6] odd (0=even). With par_en=1, a parity bit
//   follows the data on TX. RX checks it; a mismatch sets parity_err and drops the byte.
//   STATUS[9] is live.
//  UART_PARITY_EN undefined: no PARITY state, CTRL[6:5] read 0, STATUS[9] always 0, 8N1 only.
// TESTING
//  Reset, then read STATUS -> 0x006 (tx_empty, rx_empty); DIVISOR reads 868; tx=1.
//  DIVISOR=4, CTRL=1, write DATA 0x55,0xA3 -> tx shows 0,10101010,1,0,11000101,1; 4 clk/bit, no gap.
//  CTRL=0x13 (loopback), write 0x3C -> after 40 clk rx_empty=0; DATA read gives 0x3C next cycle.
//  Loopback, rx_en=1, push RX_DEPTH+1 bytes -> rx_full=1, rx_ovr=1, first RX_DEPTH bytes read intact;
//   write STATUS 0x40 -> rx_ovr=0.
//  rx low for 1 clk at DIVISOR=8 -> false start, no push; hold rx low 10 bits -> frame_err=1, no push.
//  UART_PARITY_EN, CTRL=0x33, send 0x07 -> parity bit 1; force a bad parity on rx -> parity_err=1.

Source files
------------

// File: rtl/uart_fifo_io_if.sv
// rtl/uart_fifo_io_if.sv - CPU-side register bus bundle for uart_fifo_io
//
// Signals: addr[3:0] register word index, data_in[31:0] write data,
// data_out[31:0] registered read data, MemEn access strobe, MemWen 1=write.
// master: CPU / testbench side. slave: the UART peripheral.
interface uart_fifo_io_if;
    logic [3:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        MemEn;
    logic        MemWen;

    modport master (output addr, data_in, MemEn, MemWen, input data_out);
    modport slave  (input addr, data_in, MemEn, MemWen, output data_out);
endinterface

// File: rtl/uart_fifo_io.sv
// rtl/uart_fifo_io.sv - memory-mapped UART with TX/RX FIFOs, runtime divisor, sticky flags, irq
//
// Ports:
//   clk    system clock, posedge
//   rst_n  asynchronous active-low reset
//   bus    uart_fifo_io_if.slave register bus (addr, data_in, data_out, MemEn, MemWen)
//   tx     serial out, idle high
//   rx     serial in, asynchronous to clk
//   busy   tx_busy | rx_busy
//   irq    level interrupt
// Registers: 0 CTRL, 1 DATA, 2 STATUS (W1C flags), 3 DIVISOR.
// Optional feature macro: UART_PARITY_EN adds CTRL[5] par_en, CTRL[6] odd and a parity bit.
module uart_fifo_io #(
    parameter int CLK_DIV_RST = 868,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    uart_fifo_io_if.slave bus,
    output logic          tx,
    input  logic          rx,
    output logic          busy,
    output logic          irq
);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam logic [15:0] DIV_RST = 16'(CLK_DIV_RST);

`ifdef UART_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PAR, ST_STOP} st_e;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} st_e;
`endif

    // ---------------- register bus decode ----------------
    logic wr_en, rd_en, wr_ctrl, wr_data, wr_stat, wr_div, rd_data;
    assign wr_en   = bus.MemEn & bus.MemWen;
    assign rd_en   = bus.MemEn & ~bus.MemWen;
    assign wr_ctrl = wr_en && (bus.addr == 4'd0);
    assign wr_data = wr_en && (bus.addr == 4'd1);
    assign wr_stat = wr_en && (bus.addr == 4'd2);
    assign wr_div  = wr_en && (bus.addr == 4'd3);
    assign rd_data = rd_en && (bus.addr == 4'd1);

    logic unused_bits;
    assign unused_bits = ^bus.data_in[31:16];

    logic [6:0]  ctrl_q;
    logic [15:0] div_q;
    logic        rx_ovr_q, frame_err_q, tx_ovr_q, parity_err_q;
    logic [31:0] data_out_q;
    logic [31:0] rd_mux;

    // ---------------- FIFOs ----------------
    logic [7:0]   tx_mem [TX_DEPTH];
    logic [7:0]   rx_mem [RX_DEPTH];
    logic [TAW:0] tx_wp_q, tx_rp_q;
    logic [RAW:0] rx_wp_q, rx_rp_q;
    logic tx_empty, tx_full, rx_empty, rx_full;
    logic tx_push, tx_pop, rx_push, rx_pop;

    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[TAW] != tx_rp_q[TAW]) && (tx_wp_q[TAW-1:0] == tx_rp_q[TAW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[RAW] != rx_rp_q[RAW]) && (rx_wp_q[RAW-1:0] == rx_rp_q[RAW-1:0]);

    // ---------------- TX serializer state ----------------
    st_e         tx_st_q;
    logic        tx_q;
    logic [15:0] tx_cnt_q, tx_div_q;
    logic [7:0]  tx_sh_q;
    logic [2:0]  tx_bit_q;
    logic        tx_tick, tx_busy;
`ifdef UART_PARITY_EN
    logic        tx_par_en_q, tx_par_q;
`endif

    assign tx_tick = (tx_cnt_q == tx_div_q - 16'd1);
    assign tx_busy = (tx_st_q != ST_IDLE);
    // Pop from IDLE or at the last cycle of STOP so consecutive frames abut.
    assign tx_pop  = ctrl_q[0] && !tx_empty &&
                     ((tx_st_q == ST_IDLE) || ((tx_st_q == ST_STOP) && tx_tick));
    // A full FIFO still accepts a byte when the serializer pops in the same cycle.
    assign tx_push = wr_data && (!tx_full || tx_pop);

    // ---------------- RX deserializer state ----------------
    st_e         rx_st_q;
    logic        rx_s1_q, rx_s2_q, rx_prev_q;
    logic [15:0] rx_cnt_q, rx_div_q;
    logic [7:0]  rx_sh_q;
    logic [2:0]  rx_bit_q;
    logic        rx_src, rx_fall, rx_tick, rx_busy, rx_done, rx_par_bad;
`ifdef UART_PARITY_EN
    logic        rx_par_en_q, rx_pbad_q;
    assign rx_par_bad = rx_pbad_q;
`else
    assign rx_par_bad = 1'b0;
`endif

    assign rx_src  = ctrl_q[4] ? tx_q : rx_s2_q;
    assign rx_fall = rx_prev_q & ~rx_src;
    assign rx_tick = (rx_cnt_q == rx_div_q - 16'd1);
    assign rx_busy = (rx_st_q != ST_IDLE);
    // rx_done: stop bit sampled high; the byte is good unless parity failed.
    assign rx_done = (rx_st_q == ST_STOP) && rx_tick && rx_src;
    assign rx_pop  = rd_data && !rx_empty;
    assign rx_push = rx_done && !rx_par_bad && (!rx_full || rx_pop);

    // ---------------- register file / flags / read port ----------------
    always_comb begin
        rd_mux = 32'd0;
        case (bus.addr)
            4'd0: rd_mux = {25'd0, ctrl_q};
            4'd1: rd_mux = rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rp_q[RAW-1:0]]};
            4'd2: rd_mux = {22'd0, parity_err_q, tx_ovr_q, frame_err_q, rx_ovr_q,
                            rx_busy, tx_busy, rx_full, rx_empty, tx_empty, tx_full};
            4'd3: rd_mux = {16'd0, div_q};
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= 7'd0;
            div_q        <= DIV_RST;
            rx_ovr_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            tx_ovr_q     <= 1'b0;
            parity_err_q <= 1'b0;
            data_out_q   <= 32'd0;
            tx_wp_q      <= '0;
            rx_wp_q      <= '0;
            rx_rp_q      <= '0;
        end else begin
            if (wr_ctrl) begin
`ifdef UART_PARITY_EN
                ctrl_q <= bus.data_in[6:0];
`else
                ctrl_q <= {2'b00, bus.data_in[4:0]};
`endif
            end
            if (wr_div)
                div_q <= (bus.data_in[15:0] < 16'd4) ? 16'd4 : bus.data_in[15:0];
            // Set wins over a simultaneous write-1-to-clear.
            rx_ovr_q     <= (rx_ovr_q & ~(wr_stat & bus.data_in[6])) |
                            (rx_done & !rx_par_bad & rx_full & !rx_pop);
            frame_err_q  <= (frame_err_q & ~(wr_stat & bus.data_in[7])) |
                            ((rx_st_q == ST_STOP) & rx_tick & ~rx_src);
            tx_ovr_q     <= (tx_ovr_q & ~(wr_stat & bus.data_in[8])) |
                            (wr_data & tx_full & !tx_pop);
            parity_err_q <= (parity_err_q & ~(wr_stat & bus.data_in[9])) | (rx_done & rx_par_bad);
            if (tx_push) tx_wp_q <= tx_wp_q + 1'b1;
            if (rx_push) rx_wp_q <= rx_wp_q + 1'b1;
            if (rx_pop)  rx_rp_q <= rx_rp_q + 1'b1;
            if (rd_en)   data_out_q <= rd_mux;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TAW-1:0]] <= bus.data_in[7:0];
        if (rx_push) rx_mem[rx_wp_q[RAW-1:0]] <= rx_sh_q;
    end

    // ---------------- TX FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_st_q  <= ST_IDLE;
            tx_q     <= 1'b1;
            tx_cnt_q <= 16'd0;
            tx_div_q <= 16'd4;
            tx_sh_q  <= 8'd0;
            tx_bit_q <= 3'd0;
            tx_rp_q  <= '0;
`ifdef UART_PARITY_EN
            tx_par_en_q <= 1'b0;
            tx_par_q    <= 1'b0;
`endif
        end else if (tx_pop) begin
            // Divisor and framing options are captured per frame.
            tx_st_q  <= ST_START;
            tx_q     <= 1'b0;
            tx_cnt_q <= 16'd0;
            tx_div_q <= div_q;
            tx_sh_q  <= tx_mem[tx_rp_q[TAW-1:0]];
            tx_bit_q <= 3'd0;
            tx_rp_q  <= tx_rp_q + 1'b1;
`ifdef UART_PARITY_EN
            tx_par_en_q <= ctrl_q[5];
            tx_par_q    <= (^tx_mem[tx_rp_q[TAW-1:0]]) ^ ctrl_q[6];
`endif
        end else begin
            case (tx_st_q)
                ST_IDLE: tx_q <= 1'b1;
                ST_START: begin
                    if (tx_tick) begin
                        tx_st_q  <= ST_DATA;
                        tx_cnt_q <= 16'd0;
                        tx_q     <= tx_sh_q[0];
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (tx_tick) begin
                        tx_cnt_q <= 16'd0;
                        if (tx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            if (tx_par_en_q) begin
                                tx_st_q <= ST_PAR;
                                tx_q    <= tx_par_q;
                            end else begin
                                tx_st_q <= ST_STOP;
                                tx_q    <= 1'b1;
                            end
`else
                            tx_st_q <= ST_STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            tx_bit_q <= tx_bit_q + 3'd1;
                            tx_sh_q  <= {1'b0, tx_sh_q[7:1]};
                            tx_q     <= tx_sh_q[1];
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PAR: begin
                    if (tx_tick) begin
                        tx_st_q  <= ST_STOP;
                        tx_cnt_q <= 16'd0;
                        tx_q     <= 1'b1;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tx_tick) begin
                        tx_st_q  <= ST_IDLE;
                        tx_cnt_q <= 16'd0;
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 16'd1;
                    end
                end
                default: begin
                    tx_st_q <= ST_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    // ---------------- RX FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
            rx_st_q   <= ST_IDLE;
            rx_cnt_q  <= 16'd0;
            rx_div_q  <= 16'd4;
            rx_sh_q   <= 8'd0;
            rx_bit_q  <= 3'd0;
`ifdef UART_PARITY_EN
            rx_par_en_q <= 1'b0;
            rx_pbad_q   <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_src;
            case (rx_st_q)
                ST_IDLE: begin
                    if (ctrl_q[1] && rx_fall) begin
                        rx_st_q  <= ST_START;
                        rx_cnt_q <= 16'd0;
                        rx_div_q <= div_q;
`ifdef UART_PARITY_EN
                        rx_par_en_q <= ctrl_q[5];
                        rx_pbad_q   <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    // Mid-bit re-check of the start bit; a high level means a glitch.
                    if (rx_cnt_q == (rx_div_q >> 1) - 16'd1) begin
                        rx_cnt_q <= 16'd0;
                        rx_bit_q <= 3'd0;
                        rx_st_q  <= rx_src ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                ST_DATA: begin
                    if (rx_tick) begin
                        rx_cnt_q <= 16'd0;
                        rx_sh_q  <= {rx_src, rx_sh_q[7:1]};
                        rx_bit_q <= rx_bit_q + 3'd1;
                        if (rx_bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_st_q <= rx_par_en_q ? ST_PAR : ST_STOP;
`else
                            rx_st_q <= ST_STOP;
`endif
                        end
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
`ifdef UART_PARITY_EN
                ST_PAR: begin
                    if (rx_tick) begin
                        rx_cnt_q  <= 16'd0;
                        rx_pbad_q <= rx_src != ((^rx_sh_q) ^ ctrl_q[6]);
                        rx_st_q   <= ST_STOP;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_tick) begin
                        rx_cnt_q <= 16'd0;
                        rx_st_q  <= ST_IDLE;
                    end else begin
                        rx_cnt_q <= rx_cnt_q + 16'd1;
                    end
                end
                default: rx_st_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.data_out = data_out_q;
    assign tx   = tx_q;
    assign busy = tx_busy | rx_busy;
    assign irq  = (ctrl_q[2] & ~rx_empty) | (ctrl_q[3] & tx_empty & ~tx_busy) |
                  (ctrl_q[2] & (rx_ovr_q | frame_err_q | parity_err_q));
endmodule
